// File: rtl/hit_arbiter.sv
// hit_arbiter: registers landed hits between the two players, tracks damage and
// post-hit invulnerability, and queues one scaled hit event per target for the CPU.
module hit_arbiter #(
    parameter int INVULN_FRAMES = 30,
    parameter int DMG_MAX       = 999,
    parameter int KB_STEP_LOG2  = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [31:0] p1_attack,
    input  logic [31:0] p2_attack,
    input  logic [31:0] p1_knockback,
    input  logic [31:0] p2_knockback,
    input  logic [1:0]  clear_damage,
    input  logic        hit_ready,
    output logic        hit_valid,
    output logic        hit_target,
    output logic [3:0]  hit_type,
    output logic [31:0] hit_knockback,
    output logic [9:0]  p1_damage,
    output logic [9:0]  p2_damage,
    output logic        p1_invuln,
    output logic        p2_invuln,
    output logic        overflow
);
    typedef enum logic [1:0] {ARMED, CAPTURE, SPENT} state_t;

    localparam logic [7:0]  INV_LOAD = 8'(INVULN_FRAMES);
    localparam logic [10:0] DMG_SAT  = 11'(DMG_MAX);

    logic [31:0] w_attack   [2];
    logic [31:0] w_kbIn     [2];
    logic [31:0] w_scaledKb [2];
    logic [9:0]  w_dmg      [2];
    logic [3:0]  w_hitCode  [2];
    logic [3:0]  w_hitDmg   [2];
    logic [3:0]  w_slotType [2];
    logic [31:0] w_slotKb   [2];
    logic        w_full     [2];
    logic        w_invuln   [2];
    logic        w_detect   [2];
    logic        w_capture  [2];
    logic        w_pop      [2];
    logic        w_drop     [2];
    logic        w_unusedBits;
    logic        r_sel;
    logic        r_overflow;

    function automatic logic [3:0] typeCode(input logic [9:0] bits);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (bits[i]) code = 4'(i + 1);
        end
        return code;
    endfunction

    function automatic logic [3:0] damageOf(input logic [3:0] code);
        case (code)
            4'd1, 4'd2, 4'd3, 4'd4: return 4'd12;
            4'd5:                   return 4'd3;
            4'd6, 4'd7:             return 4'd8;
            4'd8, 4'd9:             return 4'd6;
            4'd10:                  return 4'd4;
            default:                return 4'd0;
        endcase
    endfunction

    assign w_attack[0]  = p1_attack;
    assign w_attack[1]  = p2_attack;
    assign w_kbIn[0]    = p1_knockback;
    assign w_kbIn[1]    = p2_knockback;
    assign w_unusedBits = &{p1_attack[31:13], p2_attack[31:13]};

    // Index p is both "player p as attacker" and "player p as target / slot p".
    for (genvar p = 0; p < 2; p++) begin : g_player
        localparam int T = 1 - p;

        state_t      r_state;
        logic [3:0]  r_code;
        logic [3:0]  r_dmgAdd;
        logic [9:0]  r_dmg;
        logic [7:0]  r_invCnt;
        logic        r_full;
        logic [3:0]  r_slotType;
        logic [31:0] r_slotKb;
        logic [3:0]  w_code;
        logic [9:0]  w_steps;
        logic [15:0] w_mult;
        logic [10:0] w_sum;

        assign w_code        = typeCode(w_attack[p][10:1]);
        assign w_invuln[p]   = (r_invCnt != 8'd0);
        assign w_detect[p]   = (r_state == ARMED) & w_attack[p][0] & ~w_attack[T][12] & ~w_invuln[T];
        assign w_capture[p]  = (r_state == CAPTURE);
        assign w_hitCode[p]  = r_code;
        assign w_hitDmg[p]   = r_dmgAdd;
        assign w_dmg[p]      = r_dmg;
        assign w_full[p]     = r_full;
        assign w_slotType[p] = r_slotType;
        assign w_slotKb[p]   = r_slotKb;

        // Knockback multiplier comes from the target's damage before this hit lands.
        assign w_steps       = w_dmg[T] >> KB_STEP_LOG2;
        assign w_mult        = (w_steps > 10'd3) ? 16'd4 : 16'(w_steps) + 16'd1;
        assign w_scaledKb[p] = {w_kbIn[p][31:16] * w_mult, w_kbIn[p][15:0] * w_mult};

        assign w_sum    = {1'b0, r_dmg} + {7'd0, w_hitDmg[T]};
        assign w_pop[p] = hit_ready & r_full & (r_sel == 1'(p));
        assign w_drop[p] = w_capture[T] & r_full & ~w_pop[p];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_state  <= ARMED;
                r_code   <= 4'd0;
                r_dmgAdd <= 4'd0;
            end else begin
                case (r_state)
                    ARMED: begin
                        if (w_detect[p]) begin
                            r_state  <= CAPTURE;
                            r_code   <= w_code;
                            r_dmgAdd <= damageOf(w_code);
                        end
                    end
                    CAPTURE: r_state <= SPENT;
                    SPENT:   if (!w_attack[p][11]) r_state <= ARMED;
                    default: r_state <= ARMED;
                endcase
            end
        end

        // Target-side state: damage, invulnerability and the pending-event slot.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_dmg      <= 10'd0;
                r_invCnt   <= 8'd0;
                r_full     <= 1'b0;
                r_slotType <= 4'd0;
                r_slotKb   <= 32'd0;
            end else begin
                if (clear_damage[p])
                    r_dmg <= 10'd0;
                else if (w_capture[T])
                    r_dmg <= (w_sum > DMG_SAT) ? 10'(DMG_SAT) : 10'(w_sum);

                if (w_detect[T])
                    r_invCnt <= INV_LOAD;
                else if (frame_tick && r_invCnt != 8'd0)
                    r_invCnt <= r_invCnt - 8'd1;

                if (w_capture[T]) begin
                    if (!r_full || w_pop[p]) begin
                        r_full     <= 1'b1;
                        r_slotType <= w_hitCode[T];
                        r_slotKb   <= w_scaledKb[T];
                    end
                end else if (w_pop[p]) begin
                    r_full     <= 1'b0;
                    r_slotType <= 4'd0;
                    r_slotKb   <= 32'd0;
                end
            end
        end
    end

    // An empty selected slot with a full neighbour costs one bubble to swing over.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (hit_valid && hit_ready)
                r_sel <= ~r_sel;
            else if (!w_full[r_sel] && w_full[~r_sel])
                r_sel <= ~r_sel;
            if (w_drop[0] || w_drop[1])
                r_overflow <= 1'b1;
        end
    end

    assign hit_valid     = w_full[r_sel];
    assign hit_target    = r_sel;
    assign hit_type      = w_slotType[r_sel];
    assign hit_knockback = w_slotKb[r_sel];
    assign p1_damage     = w_dmg[0];
    assign p2_damage     = w_dmg[1];
    assign p1_invuln     = w_invuln[0];
    assign p2_invuln     = w_invuln[1];
    assign overflow      = r_overflow;
endmodule

// File: doc/hit_arbiter.md
# hit_arbiter

Resolves landed hits between the two players' attack coprocessors and sequences their effects on the game state. It enforces once-per-attack hit registration and post-hit invulnerability, and scales knockback by the target's accumulated damage. It keeps a saturating damage counter per player and hands hit events one at a time to the game processor over a valid/ready interface. It sits between the two attack coprocessor instances and the processor's hit-handling memory-mapped port.

## Interface
- INVULN_FRAMES, 30, frames of invulnerability given to a target after a hit is registered
- DMG_MAX, 999, saturation value of each damage counter
- KB_STEP_LOG2, 7, log2 of damage per knockback-scale step
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per game frame
- p1_attack, p2_attack  in  32  attack words from each player's coprocessor: bit0 hit-landed, bits1-10 attack type one-hot, bit11 attack active, bit12 shield
- p1_knockback, p2_knockback  in  32  attacker knockback: [31:16] X signed, [15:0] Y signed
- clear_damage  in  2  bit i zeroes the damage of player i+1 (stock loss)
- hit_ready  in  1  processor accepts the presented hit event
- hit_valid  out  1  hit event presented
- hit_target  out  1  0 = P1 was hit, 1 = P2 was hit
- hit_type  out  4  attack code 1-10 (index of lowest set bit in attack[10:1]); 0 if none set
- hit_knockback  out  32  scaled knockback, same packing as input
- p1_damage, p2_damage  out  10  damage counters
- p1_invuln, p2_invuln  out  1  target invulnerable
- overflow  out  1  sticky: a registered hit was dropped

## Operation
- One attacker FSM per player (attacker A, target T = the other player). States:
  - ARMED: on A.attack[0] & ~T.attack[12] & ~T_invuln, go to CAPTURE. Latch hit_type code and damage; load T's invuln counter with INVULN_FRAMES.
  - CAPTURE (1 cycle): latch A's knockback, scale it, write slot[T], add damage to T, go to SPENT.
  - SPENT: go to ARMED when A.attack[11] == 0.
- Damage table by code: 1-4 → 12; 5 → 3; 6-7 → 8; 8-9 → 6; 10 → 4; 0 → 0.
- Knockback scale: level = min(T_damage >> KB_STEP_LOG2, 3), using T's damage before this hit. X and Y are each multiplied by (level+1) as signed 16-bit values, truncated to 16 bits.
- Damage update: saturating add at DMG_MAX. If clear_damage[i] asserts in the same cycle as an add, the clear wins and the result is 0.
- Invuln counter: decrements on frame_tick when nonzero; invuln = (counter != 0). A load in the same cycle as a tick wins.
- Slots: one entry per target (slot0 holds hits on P1). Writing a full slot that is not popped on the same edge drops the hit and sets overflow. If the slot is popped on the same edge, the write succeeds.
- Output pointer sel starts at 0 after reset. Outputs show slot[sel], and hit_valid = slot[sel].full.
  - On the hit_valid & hit_ready edge, slot[sel] clears and sel toggles.
  - If slot[sel] is empty and the other slot is full, sel toggles. This costs a one-cycle bubble.
- Mutual hits in the same cycle: both register, since the invuln checks use pre-edge values. Both slots fill on the same edge.

## Timing
- Reset values: all FSMs ARMED, slots empty, sel=0, damage 0, invuln counters 0, overflow 0, hit_valid 0, hit_type 0, hit_knockback 0.
- Hit at attack[0] sampled edge N: invuln asserts after N, CAPTURE runs in cycle N+1, and slot/damage update at edge N+1. hit_valid is high in cycle N+2 when sel already points at the slot.
- Knockback is sampled one cycle after detection, matching the coprocessor's registered knockback.
- hit_* outputs hold stable while hit_valid & ~hit_ready.
- Reset mid-operation clears everything immediately. A pending hit is discarded.

## Test plan
- P1 smashR (attack bit4 | bit0) on P2 at damage 0, knockback 0x00080001, hit_ready=1 → one event: target=1, type=4, knockback 0x00080001; p2_damage=12; p2_invuln for 30 ticks.
- Hold attack[0] for 100 cycles with no attack[11] drop → exactly one event. Drop bit11, then re-hit after invuln expires → second event.
- P2 damage preset to 130, jabNL knockback 0xFFFC0001 → knockback 0xFFF80002, damage 133.
- Mutual hit in the same cycle with hit_ready=1 → P1-target event first, P2-target event next. Both damages update on the same edge.
- hit_ready=0, second hit on P2 after invuln expires → overflow=1, first event still presented unchanged. Target shielding (attack[12]=1) → no event, no damage.
- Damage at 995 plus smash → 999. clear_damage coincident with an add → 0. Reset asserted while hit_valid=1 → hit_valid 0 immediately.
